// File: rtl/adc_decim.sv
// Boxcar decimator: averages 2^k samples of two signed ADC channels, streams {B,A} over AXI-Stream.
// Optional build macro ADC_DECIM_ROUND_EN selects round-half-up instead of floor truncation.
module adc_decim #(
  parameter int DW       = 16,
  parameter int MAX_LOG2 = 10,
  parameter int AW       = DW + MAX_LOG2
) (
  input  logic              adc_clk,
  input  logic              adc_rst,
  input  logic [DW-1:0]     adc_da,
  input  logic [DW-1:0]     adc_db,
  input  logic              cfg_en,
  input  logic [3:0]        cfg_log2_ratio,
  output logic [2*DW-1:0]   m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              ovf_o,
  input  logic              ovf_clr
);

  typedef enum logic {IDLE, ACC} state_t;

  localparam logic [MAX_LOG2:0]     CNT_ONE = (MAX_LOG2+1)'(1);
  localparam logic signed [AW-1:0]  ACC_ONE = AW'(1);

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [MAX_LOG2-1:0]    cnt_q, cnt_d;
  logic [3:0]             k_q, k_d, k_clamp, k_cur;
  logic [MAX_LOG2:0]      cnt_last;
  logic                   absorb, last, drop;
  logic signed [AW-1:0]   sum_a, sum_b, rnd_a, rnd_b;
  logic [DW-1:0]          res_a, res_b;

  assign k_clamp = (cfg_log2_ratio > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : cfg_log2_ratio;

  always_ff @(posedge adc_clk) begin
    if (adc_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_en)  state_d = ACC;
      ACC:     if (!cfg_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In IDLE the entry sample is already the first of the window, so it uses the freshly clamped k.
  always_comb begin
    absorb = 1'b0;
    k_cur  = k_q;
    case (state_q)
      IDLE: begin
        absorb = cfg_en;
        k_cur  = k_clamp;
      end
      ACC: begin
        absorb = cfg_en;
        k_cur  = k_q;
      end
      default: begin
        absorb = 1'b0;
        k_cur  = k_q;
      end
    endcase
  end

  assign cnt_last = (CNT_ONE << k_cur) - CNT_ONE;
  assign last     = absorb && ({1'b0, cnt_q} == cnt_last);
  assign sum_a    = acc_a_q + {{(AW-DW){adc_da[DW-1]}}, adc_da};
  assign sum_b    = acc_b_q + {{(AW-DW){adc_db[DW-1]}}, adc_db};

`ifdef ADC_DECIM_ROUND_EN
  logic signed [AW-1:0] bias;
  assign bias  = (k_cur == 4'd0) ? '0 : (ACC_ONE << (k_cur - 4'd1));
  assign rnd_a = sum_a + bias;
  assign rnd_b = sum_b + bias;
`else
  logic unused_one;
  assign unused_one = ACC_ONE[0];
  assign rnd_a = sum_a;
  assign rnd_b = sum_b;
`endif

  assign res_a = DW'(rnd_a >>> k_cur);
  assign res_b = DW'(rnd_b >>> k_cur);

  always_comb begin
    acc_a_d = '0;
    acc_b_d = '0;
    cnt_d   = '0;
    k_d     = k_q;
    if (last) begin
      k_d = k_clamp;
    end else if (absorb) begin
      acc_a_d = sum_a;
      acc_b_d = sum_b;
      cnt_d   = cnt_q + MAX_LOG2'(1);
      if (state_q == IDLE) k_d = k_clamp;
    end
  end

  // A result arriving while an unaccepted beat is held is dropped; the window still restarts.
  assign drop = last && m_axis_tvalid && !m_axis_tready;

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      acc_a_q       <= '0;
      acc_b_q       <= '0;
      cnt_q         <= '0;
      k_q           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      ovf_o         <= 1'b0;
    end else begin
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      if (last && !drop) begin
        m_axis_tdata  <= {res_b, res_a};
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (drop)         ovf_o <= 1'b1;
      else if (ovf_clr) ovf_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_decim.sv
// Directed bench for adc_decim with a reference averaging model and a queue scoreboard of beats.
module tb_adc_decim;
  logic        adc_clk = 1'b0;
  logic        adc_rst;
  logic [15:0] adc_da, adc_db;
  logic        cfg_en;
  logic [3:0]  cfg_log2_ratio;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        ovf_o;
  logic        ovf_clr;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  bit          m_active = 0;
  int          m_k = 0;
  int          m_cnt = 0;
  longint      m_sa = 0, m_sb = 0;
  bit          m_ovf = 0;

  adc_decim dut (
    .adc_clk(adc_clk), .adc_rst(adc_rst), .adc_da(adc_da), .adc_db(adc_db),
    .cfg_en(cfg_en), .cfg_log2_ratio(cfg_log2_ratio),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .ovf_o(ovf_o), .ovf_clr(ovf_clr)
  );

  always #5 adc_clk = ~adc_clk;

  function automatic int clampk(input int k);
    return (k > 10) ? 10 : k;
  endfunction

  // Average by integer division, corrected toward negative infinity.
  function automatic logic [15:0] avg(input longint s_in, input int k);
    longint n, s, q;
    n = longint'(1) << k;
    s = s_in;
`ifdef ADC_DECIM_ROUND_EN
    if (k > 0) s = s + n / 2;
`endif
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return q[15:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic signed [15:0] da, input logic signed [15:0] db,
                      input bit en, input int k, input bit rdy, input bit clr, input bit rst);
    bit got;
    logic [31:0] res;
    adc_da = da; adc_db = db; cfg_en = en; cfg_log2_ratio = 4'(k);
    m_axis_tready = rdy; ovf_clr = clr; adc_rst = rst;
    #1;
    chk("tvalid", m_axis_tvalid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("tdata", m_axis_tdata, exp_q[0]);
    chk("ovf", ovf_o, m_ovf);
    if (rst) begin
      exp_q.delete();
      m_active = 0; m_cnt = 0; m_sa = 0; m_sb = 0; m_ovf = 0;
    end else begin
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      got = 0;
      res = '0;
      if (en) begin
        if (!m_active) begin
          m_active = 1; m_k = clampk(k); m_cnt = 0; m_sa = 0; m_sb = 0;
        end
        m_sa += da; m_sb += db; m_cnt++;
        if (m_cnt == (1 << m_k)) begin
          res = {avg(m_sb, m_k), avg(m_sa, m_k)};
          got = 1;
          m_cnt = 0; m_sa = 0; m_sb = 0; m_k = clampk(k);
        end
      end else begin
        m_active = 0;
      end
      if (got && exp_q.size() != 0) m_ovf = 1;
      else begin
        if (got) exp_q.push_back(res);
        if (clr) m_ovf = 0;
      end
    end
    @(posedge adc_clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    logic [31:0] t1_exp;
`ifdef ADC_DECIM_ROUND_EN
    t1_exp = 32'hFFFD_0003;
`else
    t1_exp = 32'hFFFD_0002;
`endif
    adc_rst = 1; adc_da = 0; adc_db = 0; cfg_en = 0; cfg_log2_ratio = 0;
    m_axis_tready = 1; ovf_clr = 0;
    @(posedge adc_clk); #1;
    step(0, 0, 0, 0, 1, 0, 1);
    chk("rst_tdata", m_axis_tdata, 32'h0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_ovf", ovf_o, 1'b0);

    // k=2 window 1,2,3,5 / -1,-2,-3,-5
    step(1, -1, 1, 2, 1, 0, 0);
    step(2, -2, 1, 2, 1, 0, 0);
    step(3, -3, 1, 2, 1, 0, 0);
    step(5, -5, 1, 2, 1, 0, 0);
    chk("k2_beat", m_axis_tdata, t1_exp);
    idle(3);

    // k=0 passthrough ramp
    for (int i = 0; i < 10; i++) step(16'(i), 100, 1, 0, 1, 0, 0);
    idle(3);

    // k=3 full-scale constants
    for (int i = 0; i < 24; i++) begin
      step(16'sh7FFF, 16'sh8000, 1, 3, 1, 0, 0);
      if (i == 7) chk("k3_fullscale", m_axis_tdata, 32'h8000_7FFF);
    end
    idle(3);

    // k=1 backpressure: first beat held, later ones dropped
    for (int i = 0; i < 6; i++) step(16'(10 * i), -16'(i), 1, 1, 0, 0, 0);
    chk("bp_ovf_set", ovf_o, 1'b1);
    idle(3);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("bp_ovf_clr", ovf_o, 1'b0);
    idle(2);

    // k=4 reset mid-window, then a full window after release
    for (int i = 0; i < 7; i++) step(16'(i + 1), 16'(i), 1, 4, 1, 0, 0);
    step(99, 99, 1, 4, 1, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step(16'(3 * i), -16'(i), 1, 4, 1, 0, 0);
      if (i == 14) chk("rst_no_early", m_axis_tvalid, 1'b0);
      if (i == 15) chk("rst_beat16", m_axis_tvalid, 1'b1);
    end
    idle(3);

    // k change mid-window takes effect at the boundary; cfg_en=0 drops partial window
    step(4, 8, 1, 2, 1, 0, 0);
    step(5, 9, 1, 1, 1, 0, 0);
    step(6, 10, 1, 1, 1, 0, 0);
    step(7, 11, 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(16'(-7 - i), 16'(i), 1, 1, 1, 0, 0);
    step(1000, 1000, 1, 2, 1, 0, 0);
    idle(4);

    // clamp: k=15 behaves as 2^10
    for (int i = 0; i < 1024; i++) step(16'($urandom), 16'($urandom), 1, 15, 1, 0, 0);
    idle(3);

    // random data and random backpressure at k=2
    for (int i = 0; i < 60; i++)
      step(16'($urandom), 16'($urandom), 1, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
